// File: rtl/dijkstra_pkg.sv
// Types and constants shared by the Dijkstra relaxation engine and the path tracer.
package dijkstra_pkg;

    localparam int unsigned NODE_WIDTH      = 5;
    localparam int unsigned NO_PRED_DEFAULT = (1 << NODE_WIDTH) - 1;

    typedef logic [NODE_WIDTH-1:0] node_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CHK,
        EMIT,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_UNREACH = 2'd1,
        ERR_LOOP    = 2'd2
    } err_e;

endpackage

// File: rtl/path_stack.sv
// LIFO holding the nodes visited while walking the predecessor chain.
module path_stack #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] top,
    output logic [ADDR_WIDTH:0]   depth
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic [ADDR_WIDTH:0]   sp_q, sp_d;
    logic [ADDR_WIDTH-1:0] top_idx;

    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + (ADDR_WIDTH+1)'(1);
        end else if (pop) begin
            sp_d = sp_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            entry_q[sp_q[ADDR_WIDTH-1:0]] <= din;
        end
    end

    assign top_idx = sp_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign top     = (sp_q == '0) ? '0 : entry_q[top_idx];
    assign depth   = sp_q;

    push_pop_exclusive: assert property (@(posedge clk) disable iff (reset) !(push && pop));

endmodule

// File: rtl/path_tracer.sv
// Walks the predecessor memory from dst back to src, then streams the route source-first.
module path_tracer
    import dijkstra_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NODE_WIDTH,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NO_PRED    = (1 << DATA_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  start_ready,
    input  logic [DATA_WIDTH-1:0] src,
    input  logic [DATA_WIDTH-1:0] dst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_node,
    output logic                  out_last,
    output logic                  done,
    output logic [1:0]            err,
    output logic [ADDR_WIDTH:0]   path_len
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    state_e                state_q, state_d;
    err_e                  err_q, err_d;
    logic [DATA_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    logic                  push, pop, clear;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] stack_top;
    logic [ADDR_WIDTH:0]   stack_depth;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        src_d     = src_q;
        addr_d    = addr_q;
        len_d     = len_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        push_data = dst;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src;
                    err_d = ERR_OK;
                    push  = 1'b1;
                    len_d = (ADDR_WIDTH+1)'(1);
                    if (dst == src) begin
                        state_d = EMIT;
                        valid_d = 1'b1;
                    end else begin
                        addr_d  = ADDR_WIDTH'(dst);
                        state_d = REQ;
                    end
                end
            end
            REQ: state_d = CHK;
            CHK: begin
                if (mem_q == DATA_WIDTH'(NO_PRED)) begin
                    err_d   = ERR_UNREACH;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else if (len_q == MAX_LEN) begin
                    // A simple path never has more nodes than the memory has entries.
                    err_d   = ERR_LOOP;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    push      = 1'b1;
                    push_data = mem_q;
                    len_d     = len_q + (ADDR_WIDTH+1)'(1);
                    addr_d    = ADDR_WIDTH'(mem_q);
                    if (mem_q == src_q) begin
                        state_d = EMIT;
                        valid_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pop = 1'b1;
                    if (stack_depth == (ADDR_WIDTH+1)'(1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= ERR_OK;
            src_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    path_stack #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_stack (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .clear(clear),
        .din  (push_data),
        .top  (stack_top),
        .depth(stack_depth)
    );

    assign start_ready = (state_q == IDLE);
    assign mem_addr    = addr_q;
    assign out_valid   = valid_q;
    assign out_node    = stack_top;
    assign out_last    = valid_q && (stack_depth == (ADDR_WIDTH+1)'(1));
    assign done        = done_q;
    assign err         = err_q;
    assign path_len    = len_q;

endmodule
